// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - priority arbiter sharing one tone generator between four game sound sources
module sound_arbiter #(
  parameter logic [25:0] UNIT_CYCLES = 26'd500000,
  parameter logic [7:0]  DUR0        = 8'd50,
  parameter logic [7:0]  DUR1        = 8'd5,
  parameter logic [7:0]  DUR2        = 8'd3,
  parameter logic [7:0]  DUR3        = 8'd20,
  parameter logic [9:0]  FREQ0       = 10'd523,
  parameter logic [9:0]  FREQ1       = 10'd262,
  parameter logic [9:0]  FREQ2       = 10'd196,
  parameter logic [9:0]  FREQ3       = 10'd392,
  parameter logic [25:0] GAP_CYCLES  = 26'd250000,
  parameter logic        PREEMPT     = 1'b1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       sound_en,
  output logic [9:0] sound_freq,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Terminal counts; a zero parameter behaves as one so every phase lasts at least a cycle.
  localparam logic [25:0] UNIT_LAST = (UNIT_CYCLES == 26'd0) ? 26'd0 : UNIT_CYCLES - 26'd1;
  localparam logic [25:0] GAP_LAST  = (GAP_CYCLES == 26'd0) ? 26'd0 : GAP_CYCLES - 26'd1;

  state_t      state_q;
  logic [3:0]  pending_q;
  logic [3:0]  pending_d;
  logic [25:0] cyc_q;
  logic [7:0]  unit_q;
  logic [7:0]  dur_last_q;
  logic        sound_en_q;
  logic [9:0]  sound_freq_q;
  logic [1:0]  grant_id_q;
  logic        busy_q;
  logic        done_q;

  logic [1:0]  sel_idx;
  logic [3:0]  lower_mask;
  logic        preempt_hit;
  logic        grant_now;

  function automatic logic [1:0] lowest_set(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [9:0] freq_of(input logic [1:0] k);
    case (k)
      2'd0:    return FREQ0;
      2'd1:    return FREQ1;
      2'd2:    return FREQ2;
      default: return FREQ3;
    endcase
  endfunction

  // Last unit index of a sound, with a zero duration stretched to one unit.
  function automatic logic [7:0] dur_last_of(input logic [1:0] k);
    logic [7:0] d;
    case (k)
      2'd0:    d = DUR0;
      2'd1:    d = DUR1;
      2'd2:    d = DUR2;
      default: d = DUR3;
    endcase
    return (d == 8'd0) ? 8'd0 : d - 8'd1;
  endfunction

  // Grant decision and pending-queue next state; a new request beats a same-edge grant clear.
  always_comb begin
    sel_idx     = lowest_set(pending_q);
    lower_mask  = (4'd1 << grant_id_q) - 4'd1;
    preempt_hit = PREEMPT && ((pending_q & lower_mask) != 4'd0);
    grant_now   = !mute && (((state_q == IDLE) && (pending_q != 4'd0)) ||
                            ((state_q == PLAY) && preempt_hit));
    pending_d   = pending_q;
    if (mute) begin
      pending_d = 4'd0;
    end else begin
      if (grant_now) pending_d = pending_d & ~(4'd1 << sel_idx);
      pending_d = pending_d | req;
    end
  end

  // Main FSM with registered outputs: IDLE -> PLAY -> GAP -> IDLE, mute and preemption override.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= IDLE;
      pending_q    <= 4'd0;
      cyc_q        <= 26'd0;
      unit_q       <= 8'd0;
      dur_last_q   <= 8'd0;
      sound_en_q   <= 1'b0;
      sound_freq_q <= 10'd0;
      grant_id_q   <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      pending_q <= pending_d;
      done_q    <= 1'b0;
      if (mute) begin
        state_q    <= IDLE;
        sound_en_q <= 1'b0;
        busy_q     <= 1'b0;
        cyc_q      <= 26'd0;
        unit_q     <= 8'd0;
      end else if (grant_now) begin
        state_q      <= PLAY;
        grant_id_q   <= sel_idx;
        sound_freq_q <= freq_of(sel_idx);
        dur_last_q   <= dur_last_of(sel_idx);
        cyc_q        <= 26'd0;
        unit_q       <= 8'd0;
        busy_q       <= 1'b1;
        // A preempting sound keeps the tone running; a fresh grant from IDLE spends one setup cycle.
        sound_en_q   <= (state_q == PLAY);
      end else begin
        case (state_q)
          IDLE: begin
          end
          PLAY: begin
            if (!sound_en_q) begin
              sound_en_q <= 1'b1;
            end else if (cyc_q == UNIT_LAST) begin
              cyc_q <= 26'd0;
              if (unit_q == dur_last_q) begin
                unit_q     <= 8'd0;
                done_q     <= 1'b1;
                sound_en_q <= 1'b0;
                state_q    <= GAP;
              end else begin
                unit_q <= unit_q + 8'd1;
              end
            end else begin
              cyc_q <= cyc_q + 26'd1;
            end
          end
          GAP: begin
            if (cyc_q == GAP_LAST) begin
              cyc_q   <= 26'd0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              cyc_q <= cyc_q + 26'd1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign sound_en   = sound_en_q;
  assign sound_freq = sound_freq_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
